mem_arbiter: RTL and testbench

Two-master, single-outstanding arbiter that shares the one physical memory bus between two requesters (port 0: the MMU's downstream request port; port 1: a secondary master such as the loader/DMA). It latches single-cycle request pulses and grants round-robin. It forwards one transaction at a time downstream using the codebase's `request_enable`/`response_enable` pulse handshake. It routes the response back to the granted master.

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus, one transaction in flight at a time.
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that answers with ERR_DATA after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_request_enable,
  input  logic        m0_req_mode,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  output logic        m0_response_enable,
  output logic [31:0] m0_resp_data,
  input  logic        m1_request_enable,
  input  logic        m1_req_mode,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  output logic        m1_response_enable,
  output logic [31:0] m1_resp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_error
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_reg;
  logic        grant_id_reg;
  logic        last_grant_reg;
  logic [1:0]  rsp_en_reg;
  logic [31:0] rsp_data_reg [2];

  logic [1:0]  in_en;
  logic [1:0]  in_mode;
  logic [31:0] in_addr  [2];
  logic [31:0] in_wdata [2];
  logic [3:0]  in_wstrb [2];

  logic [1:0]  pend_valid;
  logic [1:0]  pend_mode;
  logic [31:0] pend_addr  [2];
  logic [31:0] pend_wdata [2];
  logic [3:0]  pend_wstrb [2];

  logic [1:0]  in_flight;
  logic [1:0]  accept;
  logic [1:0]  cand;
  logic        grant_fire;
  logic        grant_port;
  logic        timeout_hit;
  logic        txn_done;
  logic        sel_mode;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  assign in_en       = {m1_request_enable, m0_request_enable};
  assign in_mode     = {m1_req_mode, m0_req_mode};
  assign in_addr[0]  = m0_req_addr;
  assign in_addr[1]  = m1_req_addr;
  assign in_wdata[0] = m0_req_wdata;
  assign in_wdata[1] = m1_req_wdata;
  assign in_wstrb[0] = m0_req_wstrb;
  assign in_wstrb[1] = m1_req_wstrb;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] timeout_cnt_reg;
  assign timeout_hit = (state_reg == S_WAIT) && !response_enable &&
                       (timeout_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_cfg;
  assign unused_cfg    = ERR_DATA ^ 32'(TIMEOUT_CYCLES);
  assign timeout_hit   = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // The in-flight transaction retires this cycle, so a new pulse from its owner is legal.
  assign txn_done = (state_reg == S_WAIT) && (response_enable || timeout_hit);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic        valid_reg;
      logic        mode_reg;
      logic [31:0] addr_reg;
      logic [31:0] wdata_reg;
      logic [3:0]  wstrb_reg;

      assign in_flight[gi] = (state_reg == S_WAIT) && (grant_id_reg == 1'(gi)) && !txn_done;
      assign accept[gi]    = in_en[gi] && !valid_reg && !in_flight[gi];
      assign cand[gi]      = valid_reg || accept[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          mode_reg  <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          wstrb_reg <= '0;
        end else if (grant_fire && (grant_port == 1'(gi))) begin
          valid_reg <= 1'b0;
        end else if (accept[gi]) begin
          valid_reg <= 1'b1;
          mode_reg  <= in_mode[gi];
          addr_reg  <= in_addr[gi];
          wdata_reg <= in_wdata[gi];
          wstrb_reg <= in_wstrb[gi];
        end
      end

      assign pend_valid[gi] = valid_reg;
      assign pend_mode[gi]  = mode_reg;
      assign pend_addr[gi]  = addr_reg;
      assign pend_wdata[gi] = wdata_reg;
      assign pend_wstrb[gi] = wstrb_reg;
    end
  endgenerate

  assign grant_fire = (state_reg == S_IDLE) && (|cand);
  assign grant_port = (&cand) ? ~last_grant_reg : cand[1];

  // A pending buffer always predates a same-cycle pulse, so it takes priority.
  assign sel_mode  = pend_valid[grant_port] ? pend_mode[grant_port]  : in_mode[grant_port];
  assign sel_addr  = pend_valid[grant_port] ? pend_addr[grant_port]  : in_addr[grant_port];
  assign sel_wdata = pend_valid[grant_port] ? pend_wdata[grant_port] : in_wdata[grant_port];
  assign sel_wstrb = pend_valid[grant_port] ? pend_wstrb[grant_port] : in_wstrb[grant_port];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      request_enable  <= 1'b0;
      req_mode        <= 1'b0;
      req_addr        <= '0;
      req_wdata       <= '0;
      req_wstrb       <= '0;
      grant_id_reg    <= 1'b0;
      last_grant_reg  <= 1'b1;
      rsp_en_reg      <= '0;
      rsp_data_reg[0] <= '0;
      rsp_data_reg[1] <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_cnt_reg <= '0;
      timeout_error   <= 1'b0;
`endif
    end else begin
      request_enable <= 1'b0;
      rsp_en_reg     <= '0;
`ifdef ARB_TIMEOUT_EN
      timeout_error  <= 1'b0;
`endif
      case (state_reg)
        S_IDLE: begin
          if (grant_fire) begin
            req_mode       <= sel_mode;
            req_addr       <= sel_addr;
            req_wdata      <= sel_wdata;
            req_wstrb      <= sel_wstrb;
            request_enable <= 1'b1;
            grant_id_reg   <= grant_port;
            last_grant_reg <= grant_port;
            state_reg      <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (response_enable) begin
            rsp_en_reg[grant_id_reg]   <= 1'b1;
            rsp_data_reg[grant_id_reg] <= resp_data;
            state_reg                  <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
          end else if (timeout_hit) begin
            rsp_en_reg[grant_id_reg]   <= 1'b1;
            rsp_data_reg[grant_id_reg] <= ERR_DATA;
            timeout_error              <= 1'b1;
            state_reg                  <= S_IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
`endif
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign m0_response_enable = rsp_en_reg[0];
  assign m1_response_enable = rsp_en_reg[1];
  assign m0_resp_data       = rsp_data_reg[0];
  assign m1_resp_data       = rsp_data_reg[1];
  assign busy               = (state_reg == S_WAIT);
  assign grant_id           = grant_id_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table for basic/corner flows, plus fairness and WAIT-watchdog sequences.
module tb_mem_arbiter;

  localparam logic        MEMREQ_READ  = 1'b0;
  localparam logic        MEMREQ_WRITE = 1'b1;
  localparam logic [31:0] A0 = 32'h8000_0010;
  localparam logic [31:0] W0 = 32'h1111_2222;
  localparam logic [3:0]  S0 = 4'b1111;
  localparam logic [31:0] A1 = 32'h8000_1000;
  localparam logic [31:0] W1 = 32'hA5A5_A5A5;
  localparam logic [3:0]  S1 = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_request_enable = 1'b0;
  logic        m0_req_mode = MEMREQ_READ;
  logic [31:0] m0_req_addr = A0;
  logic [31:0] m0_req_wdata = W0;
  logic [3:0]  m0_req_wstrb = S0;
  logic        m0_response_enable;
  logic [31:0] m0_resp_data;
  logic        m1_request_enable = 1'b0;
  logic        m1_req_mode = MEMREQ_WRITE;
  logic [31:0] m1_req_addr = A1;
  logic [31:0] m1_req_wdata = W1;
  logic [3:0]  m1_req_wstrb = S1;
  logic        m1_response_enable;
  logic [31:0] m1_resp_data;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable = 1'b0;
  logic [31:0] resp_data = '0;
  logic        busy;
  logic        grant_id;
  logic        timeout_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .m0_request_enable(m0_request_enable), .m0_req_mode(m0_req_mode), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_response_enable(m0_response_enable), .m0_resp_data(m0_resp_data),
    .m1_request_enable(m1_request_enable), .m1_req_mode(m1_req_mode), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_response_enable(m1_response_enable), .m1_resp_data(m1_resp_data),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .busy(busy), .grant_id(grant_id), .timeout_error(timeout_error)
  );

  typedef struct {
    logic        rst;
    logic        m0;
    logic        m1;
    logic        resp;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_grant;
    logic        e_busy;
    logic        e_r0;
    logic        e_r1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    m0_request_enable = 1'b0;
    m1_request_enable = 1'b0;
    response_enable = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_req(input int step, output int waited);
    logic found;
    found = 1'b0;
    waited = 0;
    while (!found && waited < 10) begin
      @(negedge clk);
      waited++;
      if (request_enable) found = 1'b1;
    end
    check("req_seen", step, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold [2];
    logic        prev_rst;
    logic [31:0] prev_rdata;
    logic        exp_g;
    int          waited;

    // rst, m0, m1, resp, rdata | req_en, grant, busy, m0_rsp, m1_rsp
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,0,0}); // 0 reset state
    vecs.push_back('{0,1,0,0,32'h0,          0,0,0,0,0}); // 1 single read
    vecs.push_back('{0,0,0,0,32'h0,          1,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,1,0,0});
    vecs.push_back('{0,0,0,1,32'h1234_5678,  0,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,1,0});
    vecs.push_back('{1,0,0,0,32'h0,          0,0,0,0,0}); // 7 reset
    vecs.push_back('{0,1,1,0,32'h0,          0,0,0,0,0}); // 8 simultaneous
    vecs.push_back('{0,0,0,0,32'h0,          1,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,1,0,0});
    vecs.push_back('{0,0,0,1,32'h0BAD_F00D,  0,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,1,0});
    vecs.push_back('{0,0,0,0,32'h0,          1,1,1,0,0}); // 13 loser at r+2, write fields
    vecs.push_back('{0,0,0,1,32'hCAFE_0001,  0,1,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,1,0,0,1});
    vecs.push_back('{0,0,1,0,32'h0,          0,1,0,0,0}); // 16
    vecs.push_back('{0,0,0,0,32'h0,          1,1,1,0,0});
    vecs.push_back('{0,1,0,1,32'h5555_AAAA,  0,1,1,0,0}); // 18 response + new pulse
    vecs.push_back('{0,0,0,0,32'h0,          0,1,0,0,1});
    vecs.push_back('{0,0,0,0,32'h0,          1,0,1,0,0});
    vecs.push_back('{0,1,0,0,32'h0,          0,0,1,0,0}); // 21 pulse while in flight: dropped
    vecs.push_back('{0,0,0,1,32'h7777_0000,  0,0,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,1,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,0,0});
    vecs.push_back('{0,0,1,0,32'h0,          0,0,0,0,0}); // 25 reset mid-WAIT
    vecs.push_back('{0,0,0,0,32'h0,          1,1,1,0,0});
    vecs.push_back('{1,0,0,0,32'h0,          0,1,1,0,0});
    vecs.push_back('{0,0,0,1,32'hBEEF_0006,  0,0,0,0,0}); // 28 late response ignored
    vecs.push_back('{0,0,0,0,32'h0,          0,0,0,0,0});
    vecs.push_back('{0,0,1,0,32'h0,          0,0,0,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          1,1,1,0,0});
    vecs.push_back('{0,0,0,1,32'h0000_0007,  0,1,1,0,0});
    vecs.push_back('{0,0,0,0,32'h0,          0,1,0,0,1});
    vecs.push_back('{0,0,0,0,32'h0,          0,1,0,0,0});

    do_reset();
    hold[0] = '0;
    hold[1] = '0;
    prev_rst = 1'b1;
    prev_rdata = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      m0_request_enable = vecs[i].m0;
      m1_request_enable = vecs[i].m1;
      response_enable = vecs[i].resp;
      resp_data = vecs[i].rdata;
      @(negedge clk);
      if (prev_rst) begin
        hold[0] = '0;
        hold[1] = '0;
        check("rst_req_mode", i, 32'(req_mode), 32'd0);
        check("rst_req_addr", i, req_addr, 32'd0);
        check("rst_req_wdata", i, req_wdata, 32'd0);
        check("rst_req_wstrb", i, 32'(req_wstrb), 32'd0);
      end
      if (vecs[i].e_r0) hold[0] = prev_rdata;
      if (vecs[i].e_r1) hold[1] = prev_rdata;
      check("request_enable", i, 32'(request_enable), 32'(vecs[i].e_req));
      check("grant_id", i, 32'(grant_id), 32'(vecs[i].e_grant));
      check("busy", i, 32'(busy), 32'(vecs[i].e_busy));
      check("m0_response_enable", i, 32'(m0_response_enable), 32'(vecs[i].e_r0));
      check("m1_response_enable", i, 32'(m1_response_enable), 32'(vecs[i].e_r1));
      check("timeout_error", i, 32'(timeout_error), 32'd0);
      check("m0_resp_data", i, m0_resp_data, hold[0]);
      check("m1_resp_data", i, m1_resp_data, hold[1]);
      if (vecs[i].e_req) begin
        check("req_mode", i, 32'(req_mode), vecs[i].e_grant ? 32'(MEMREQ_WRITE) : 32'(MEMREQ_READ));
        check("req_addr", i, req_addr, vecs[i].e_grant ? A1 : A0);
        check("req_wdata", i, req_wdata, vecs[i].e_grant ? W1 : W0);
        check("req_wstrb", i, 32'(req_wstrb), vecs[i].e_grant ? 32'(S1) : 32'(S0));
      end
      $display("row %0d: req_en=%0b grant=%0d busy=%0b rsp0=%0b rsp1=%0b",
               i, request_enable, grant_id, busy, m0_response_enable, m1_response_enable);
      prev_rst = vecs[i].rst;
      prev_rdata = vecs[i].rdata;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m0_request_enable = 1'b0;
    m1_request_enable = 1'b0;
    response_enable = 1'b0;

    // Fairness: both masters keep re-requesting, grants must alternate with no bubble.
    do_reset();
    m0_request_enable = 1'b1;
    m1_request_enable = 1'b1;
    @(posedge clk); #1;
    m0_request_enable = 1'b0;
    m1_request_enable = 1'b0;
    for (int t = 0; t < 8; t++) begin
      exp_g = t[0];
      wait_req(100 + t, waited);
      check("fair_latency", 100 + t, 32'(waited), 32'd1);
      check("fair_grant", 100 + t, 32'(grant_id), 32'(exp_g));
      check("fair_addr", 100 + t, req_addr, exp_g ? A1 : A0);
      @(posedge clk); #1;
      response_enable = 1'b1;
      resp_data = 32'hF000_0000 + 32'(t);
      @(posedge clk); #1;
      response_enable = 1'b0;
      @(negedge clk);
      check("fair_rsp0", 100 + t, 32'(m0_response_enable), 32'(!exp_g));
      check("fair_rsp1", 100 + t, 32'(m1_response_enable), 32'(exp_g));
      check("fair_data", 100 + t, exp_g ? m1_resp_data : m0_resp_data, 32'hF000_0000 + 32'(t));
      $display("fair txn %0d: grant=%0d data=%h", t, grant_id, exp_g ? m1_resp_data : m0_resp_data);
      if (exp_g) m1_request_enable = 1'b1;
      else m0_request_enable = 1'b1;
      @(posedge clk); #1;
      m0_request_enable = 1'b0;
      m1_request_enable = 1'b0;
    end

    // WAIT with no downstream response.
    do_reset();
    m0_request_enable = 1'b1;
    @(posedge clk); #1;
    m0_request_enable = 1'b0;
    wait_req(200, waited);
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("to_rsp0", 200 + k, 32'(m0_response_enable), 32'(k == 16));
      check("to_error", 200 + k, 32'(timeout_error), 32'(k == 16));
    end
    check("to_data", 216, m0_resp_data, 32'hDEAD_BEEF);
    check("to_rsp1", 216, 32'(m1_response_enable), 32'd0);
    $display("timeout txn: rsp0=%0b err=%0b data=%h", m0_response_enable, timeout_error, m0_resp_data);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    response_enable = 1'b1;
    resp_data = 32'h1357_9BDF;
    @(posedge clk); #1;
    response_enable = 1'b0;
    @(negedge clk);
    check("stray_rsp0", 221, 32'(m0_response_enable), 32'd0);
    check("stray_error", 221, 32'(timeout_error), 32'd0);
    check("stray_data", 221, m0_resp_data, 32'hDEAD_BEEF);
    check("stray_busy", 221, 32'(busy), 32'd0);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("hang_busy", 200 + k, 32'(busy), 32'd1);
      check("hang_rsp0", 200 + k, 32'(m0_response_enable), 32'd0);
      check("hang_error", 200 + k, 32'(timeout_error), 32'd0);
    end
    @(posedge clk); #1;
    response_enable = 1'b1;
    resp_data = 32'h2468_ACE0;
    @(posedge clk); #1;
    response_enable = 1'b0;
    @(negedge clk);
    check("late_rsp0", 241, 32'(m0_response_enable), 32'd1);
    check("late_data", 241, m0_resp_data, 32'h2468_ACE0);
    $display("long wait txn: rsp0=%0b data=%h", m0_response_enable, m0_resp_data);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
